// File: rtl/id_ex_pipe_stage.sv
// Generic pipeline stage register: valid/ready handshake, flush, NOP bubbles and a saturating stall counter.
// Define ID_EX_SKID_EN to add a second (skid) entry, so that o_in_ready is driven from a flop.
module id_ex_pipe_stage #(
  parameter int unsigned       DATA_W    = 86,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_in_xfer;
  logic              w_out_xfer;

  assign o_out_valid = r_valid;
  assign o_out_data  = r_data;
  assign o_stall_cnt = r_stall_cnt;
  assign w_in_xfer   = i_in_valid && o_in_ready;
  assign w_out_xfer  = r_valid && i_out_ready;

`ifdef ID_EX_SKID_EN
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_in_ready;
  logic              w_main_free;
  logic              w_valid_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic              w_skid_valid_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;

  assign o_in_ready  = r_in_ready;
  assign w_main_free = !r_valid || i_out_ready;

  // The skid entry only fills while main is stalled, and it always holds the younger beat.
  always_comb begin
    w_valid_nxt      = r_valid;
    w_data_nxt       = r_data;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_data_nxt  = r_skid_data;
    if (r_skid_valid) begin
      if (i_out_ready) begin
        w_valid_nxt      = 1'b1;
        w_data_nxt       = r_skid_data;
        w_skid_valid_nxt = 1'b0;
        w_skid_data_nxt  = NOP_VALUE;
      end
    end else if (w_in_xfer) begin
      if (w_main_free) begin
        w_valid_nxt = 1'b1;
        w_data_nxt  = i_in_data;
      end else begin
        w_skid_valid_nxt = 1'b1;
        w_skid_data_nxt  = i_in_data;
      end
    end else if (w_out_xfer) begin
      w_valid_nxt = 1'b0;
      w_data_nxt  = NOP_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_valid      <= 1'b0;
      r_data       <= NOP_VALUE;
      r_skid_valid <= 1'b0;
      r_skid_data  <= NOP_VALUE;
      r_in_ready   <= 1'b1;
    end else begin
      r_valid      <= w_valid_nxt;
      r_data       <= w_data_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_data  <= w_skid_data_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
    end
  end
`else
  assign o_in_ready = !r_valid || i_out_ready;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_valid <= 1'b0;
      r_data  <= NOP_VALUE;
    end else if (w_in_xfer) begin
      r_valid <= 1'b1;
      r_data  <= i_in_data;
    end else if (w_out_xfer) begin
      r_valid <= 1'b0;
      r_data  <= NOP_VALUE;
    end
  end
`endif

  // Flush deliberately leaves the stall counter alone; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_valid && !i_out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Scoreboard bench for id_ex_pipe_stage: a queue of held beats models the stage; a negedge monitor compares.
module tb_id_ex_pipe_stage;
  localparam int DW = 86;
  localparam int CW = 4;
`ifdef ID_EX_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam logic [DW-1:0] NOP = '0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          o_in_ready;
  logic          o_out_valid;
  logic [DW-1:0] o_out_data;
  logic [CW-1:0] o_stall_cnt;

  id_ex_pipe_stage #(.DATA_W(DW), .NOP_VALUE(NOP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(o_in_ready), .i_in_data(in_data),
    .o_out_valid(o_out_valid), .i_out_ready(out_ready), .o_out_data(o_out_data),
    .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            n_out = 0;
  int            cnt_max = (1 << CW) - 1;
  int            exp_cnt = 0;
  bit            exp_in_ready = 1'b1;
  bit            started = 1'b0;
  bit            last_acc = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: occupancy-based expectations; pops the oldest beat on each output handshake.
  always @(negedge clk) begin
    if (started) begin
      if (CAP == 1) exp_in_ready = (q.size() == 0) || out_ready;
      else          exp_in_ready = (q.size() < 2);
      check("in_ready", DW'(o_in_ready), DW'(exp_in_ready));
      check("out_valid", DW'(o_out_valid), DW'(q.size() > 0));
      check("stall_cnt", DW'(o_stall_cnt), DW'(exp_cnt));
      if (q.size() > 0) check("out_data", o_out_data, q[0]);
      else              check("nop_data", o_out_data, NOP);
      if (q.size() > 0 && out_ready) begin
        void'(q.pop_front());
        n_out++;
      end
    end
  end

  // Reference model: accepted beats join the queue; reset/flush discard everything held.
  always @(posedge clk) begin
    last_acc = in_valid && exp_in_ready;
    if (rst) begin
      q.delete();
      exp_cnt = 0;
      started = 1'b1;
      last_acc = 1'b1;
    end else begin
      if (q.size() > 0 && !out_ready && exp_cnt < cnt_max) exp_cnt++;
      if (flush) q.delete();
      else if (in_valid && exp_in_ready) q.push_back(in_data);
    end
  end

  task automatic step(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl, input bit r);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl; rst = r;
    @(posedge clk);
    #1;
  endtask

  bit            pend;
  logic [DW-1:0] rd;

  initial begin
    #1;
    // Reset with a beat offered
    step(1, DW'('h3A5), 0, 0, 1);
    step(1, DW'('h3A5), 0, 0, 1);
    step(0, '0, 1, 0, 0);
    // Streaming
    step(1, DW'(1), 1, 0, 0);
    step(1, DW'(2), 1, 0, 0);
    step(1, DW'(3), 1, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    // Backpressure: 0xA held, 0xB offered until accepted
    step(1, DW'('hA), 0, 0, 0);
    pend = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(pend, DW'('hB), 0, 0, 0);
      if (last_acc) pend = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      step(pend, DW'('hB), 1, 0, 0);
      if (last_acc) pend = 1'b0;
    end
    // Flush while holding 0xA (and 0xB with a skid entry), 0xC offered in the flush cycle
    step(1, DW'('hA), 0, 0, 0);
    if (CAP == 2) step(1, DW'('hB), 0, 0, 0);
    step(1, DW'('hC), 0, 1, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    // Saturation of the 4-bit stall counter
    step(1, DW'('hD), 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, '0, 0, 0, 0);
    check("stall_sat", DW'(o_stall_cnt), DW'(15));
    step(0, '0, 0, 0, 0);
    check("stall_hold", DW'(o_stall_cnt), DW'(15));
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    // Reset while full with out_ready and in_valid high
    step(1, DW'('hE), 0, 0, 0);
    if (CAP == 2) step(1, DW'('hF), 0, 0, 0);
    step(1, DW'('h1F), 1, 0, 1);
    check("rst_mid_valid", DW'(o_out_valid), DW'(0));
    check("rst_mid_cnt", DW'(o_stall_cnt), DW'(0));
    step(0, '0, 1, 0, 0);
    // Randomized traffic honouring the hold-while-not-ready rule
    pend = 1'b0;
    rd = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pend) begin
        pend = ($urandom_range(3) != 0);
        rd = DW'({$urandom, $urandom, $urandom});
      end
      step(pend, rd, ($urandom_range(9) < 6), ($urandom_range(29) == 0), ($urandom_range(199) == 0));
      if (last_acc) pend = 1'b0;
    end
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0, 0);
    check("drained", DW'(q.size()), DW'(0));
    check("beats_out", DW'(n_out > 10), DW'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_stage.md
Name: id_ex_pipe_stage

Overview:
- Parametrised successor to the fixed ID/EX register: a generic pipeline stage register with a valid/ready handshake, flush, and bubble insertion.
- Carries an opaque packed payload: ID-stage aluop/alusel/operands/wd/wreg concatenated by the parent.
- Sits between the decode and execute stages. Also reusable for EX/MEM and MEM/WB.
- An optional skid buffer registers in_ready to break the combinational ready path from downstream.

Parameters:
- DATA_W, 32+32+8+8+5+1=86: payload width in bits.
- NOP_VALUE, {DATA_W{1'b0}}: payload value driven when the stage holds no valid beat (bubble/NOP).
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill every beat held in the stage (branch/exception redirect).
- in_valid  in  1  upstream has a beat.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage presents a valid beat.
- out_ready  in  1  downstream consumes the beat this cycle.
- out_data  out  DATA_W  payload to downstream; equals NOP_VALUE when out_valid=0.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_valid may be asserted regardless of in_ready. in_data must hold while in_valid && !in_ready.
- Latency: one cycle from input transfer to out_valid, when the stage was empty or draining.
- Reset (rst=1 at the clock edge):
  - out_valid=0, out_data=NOP_VALUE, stall_cnt=0; skid entry (if present) empty.
  - rst has priority over flush and every transfer.
- Flush:
  - On the edge where flush=1, every held beat is discarded: out_valid=0, out_data=NOP_VALUE.
  - A beat transferred in that same cycle is also discarded. Upstream still treats it as accepted.
  - Flush has priority over input and output transfers.
  - stall_cnt is not affected by flush.
- Base mode (SKID buffer compiled out): single entry, "full" = out_valid.
  - in_ready = !out_valid || out_ready. This is combinational.
  - Input transfer: out_data<=in_data, out_valid<=1.
  - Output transfer with no input transfer: out_valid<=0, out_data<=NOP_VALUE.
  - Simultaneous output and input transfer: the new beat replaces the old one, so back-to-back throughput is 1 beat/cycle.
  - Empty and no input: out_data stays NOP_VALUE.
- Stall counter:
  - Increments by 1 on each cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Only rst clears it.
- Ordering: beats leave in arrival order. No duplication, no loss except by flush.

Optional Feature:
- Macro: ID_EX_SKID_EN.
- Defined: a second skid register is added, and occupancy can be 0, 1 or 2.
  - in_ready = !skid_full. It is driven only from a flop.
  - Input transfer while main is full and out_ready=0: the beat goes to the skid entry.
  - When main drains and skid is full: skid moves to main the same edge, and skid empties.
  - Input transfer then goes to main (if main is empty or draining with skid empty) or to skid.
  - Throughput is still 1 beat/cycle; latency is still 1 cycle when empty.
  - Flush and rst empty both entries.
- Undefined: base single-entry behaviour, with combinational in_ready.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with in_valid=1, in_data=86'h3A5.
  - Required: out_valid=0, out_data=NOP_VALUE, stall_cnt=0.
  - After release, in_ready=1.
- Streaming:
  - Stimulus: beats 1,2,3 on consecutive cycles with out_ready=1.
  - Required: out_data shows 1,2,3 one cycle after each beat, with out_valid continuously 1.
  - One cycle after the last beat: out_valid=0 and out_data=NOP_VALUE.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while beats 0xA, 0xB are offered.
  - Required: out_data holds 0xA and stall_cnt increments 1..5.
  - Base mode: in_ready=0 and 0xB waits.
  - Skid mode: 0xB is accepted, then in_ready=0.
  - After out_ready=1: 0xA then 0xB appear in order.
- Flush:
  - Stimulus: assert flush while holding 0xA (skid mode: also 0xB), with in_valid=1 and in_data=0xC in the same cycle.
  - Required next cycle: out_valid=0, out_data=NOP_VALUE; 0xA, 0xB and 0xC are never output.
- Saturation:
  - Stimulus: CNT_W=4, out_ready=0 for 20 cycles with one beat held.
  - Required: stall_cnt reaches 15 and stays at 15.
- Reset mid-operation:
  - Stimulus: rst=1 coincident with out_ready=1 and in_valid=1, with the stage full.
  - Required: the stage is empty next cycle and no beat is output.
